// File: rtl/ysyx_23060221_mem_arbiter.sv
// Round-robin two-master (IFU/LSU) to one-slave memory arbiter with a single
// outstanding transaction and a WAIT-state timeout that returns an error response.
module ysyx_23060221_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_valid_i,
  output logic        ifu_req_ready_o,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_rsp_valid_o,
  input  logic        ifu_rsp_ready_i,
  output logic [31:0] ifu_rdata_o,
  output logic        ifu_rsp_err_o,
  input  logic        lsu_req_valid_i,
  output logic        lsu_req_ready_o,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_wen_i,
  input  logic [3:0]  lsu_wmask_i,
  output logic        lsu_rsp_valid_o,
  input  logic        lsu_rsp_ready_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_rsp_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_wen_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        ifu_gnt, lsu_gnt, owner_rsp_ready;

  // A tie goes to whichever master was not granted last (0 = IFU, 1 = LSU).
  assign ifu_gnt = rst_ni && (state_q == IDLE) && ifu_req_valid_i &&
                   (!lsu_req_valid_i || last_q);
  assign lsu_gnt = rst_ni && (state_q == IDLE) && lsu_req_valid_i &&
                   (!ifu_req_valid_i || !last_q);

  assign owner_rsp_ready = owner_q ? lsu_rsp_ready_i : ifu_rsp_ready_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (lsu_gnt) begin
          owner_d = 1'b1;
          last_d  = 1'b1;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          wen_d   = lsu_wen_i;
          wmask_d = lsu_wmask_i;
          state_d = REQ;
        end else if (ifu_gnt) begin
          owner_d = 1'b0;
          last_d  = 1'b0;
          addr_d  = ifu_addr_i;
          wdata_d = 32'h0;
          wen_d   = 1'b0;
          wmask_d = 4'hF;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready_i) begin
          cnt_d   = 8'h0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the expiry cycle still wins over the timeout.
        if (mem_rsp_valid_i) begin
          rdata_d = wen_q ? 32'h0 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      RESP: begin
        if (owner_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wen_q   <= 1'b0;
      wmask_q <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifu_req_ready_o = ifu_gnt;
  assign lsu_req_ready_o = lsu_gnt;

  assign mem_req_valid_o = rst_ni && (state_q == REQ);
  assign mem_addr_o      = addr_q;
  assign mem_wdata_o     = wdata_q;
  assign mem_wen_o       = wen_q;
  assign mem_wmask_o     = wmask_q;

  assign ifu_rsp_valid_o = rst_ni && (state_q == RESP) && !owner_q;
  assign lsu_rsp_valid_o = rst_ni && (state_q == RESP) && owner_q;
  assign ifu_rdata_o     = rdata_q;
  assign lsu_rdata_o     = rdata_q;
  assign ifu_rsp_err_o   = err_q;
  assign lsu_rsp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_23060221_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT = 4.
module tb_ysyx_23060221_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060221_mem_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_req_ready),
    .ifu_addr_i(ifu_addr),
    .ifu_rsp_valid_o(ifu_rsp_valid), .ifu_rsp_ready_i(ifu_rsp_ready),
    .ifu_rdata_o(ifu_rdata), .ifu_rsp_err_o(ifu_rsp_err),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .lsu_wen_i(lsu_wen),
    .lsu_wmask_i(lsu_wmask),
    .lsu_rsp_valid_o(lsu_rsp_valid), .lsu_rsp_ready_i(lsu_rsp_ready),
    .lsu_rdata_o(lsu_rdata), .lsu_rsp_err_o(lsu_rsp_err),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wen_o(mem_wen),
    .mem_wmask_o(mem_wmask),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are changed #1 after the edge, checks a further #1 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0; lsu_wmask = 0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
    step(); step();
    ifu_req_valid = 1; settle();
    chk("rst_ifu_ready_forced", ifu_req_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    ifu_req_valid = 0;
    step(); rst_n = 1; settle();

    // Single IFU fetch, best-case turnaround
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; settle();
    chk("c0_ifu_ready", ifu_req_ready, 1);
    chk("c0_lsu_ready", lsu_req_ready, 0);
    step(); ifu_req_valid = 0; mem_req_ready = 1; settle();
    chk("c1_mem_req_valid", mem_req_valid, 1);
    chk("c1_mem_addr", mem_addr, 32'h8000_0000);
    chk("c1_mem_wen", mem_wen, 0);
    chk("c1_mem_wmask", mem_wmask, 4'hF);
    step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0073; settle();
    chk("c2_mem_req_valid", mem_req_valid, 0);
    chk("c2_ifu_rsp_valid", ifu_rsp_valid, 0);
    step(); mem_rsp_valid = 0; mem_rdata = 0; ifu_rsp_ready = 1; settle();
    chk("c3_ifu_rsp_valid", ifu_rsp_valid, 1);
    chk("c3_ifu_rdata", ifu_rdata, 32'h0010_0073);
    chk("c3_ifu_err", ifu_rsp_err, 0);
    chk("c3_lsu_rsp_valid", lsu_rsp_valid, 0);
    step(); ifu_rsp_ready = 0; settle();
    chk("c4_ifu_rsp_valid", ifu_rsp_valid, 0);

    // Tie after an IFU grant goes to LSU; LSU store with request backpressure
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wen = 1; lsu_wmask = 4'b0011; settle();
    chk("tie1_lsu_ready", lsu_req_ready, 1);
    chk("tie1_ifu_ready", ifu_req_ready, 0);
    step(); lsu_req_valid = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wen = 0; lsu_wmask = 0; settle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_mem_req_valid", mem_req_valid, 1);
      chk("bp_mem_addr", mem_addr, 32'h8000_1000);
      chk("bp_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("bp_mem_wen", mem_wen, 1);
      chk("bp_mem_wmask", mem_wmask, 4'b0011);
      chk("bp_ifu_ready_blocked", ifu_req_ready, 0);
      if (i < 4) step();
    end
    mem_req_ready = 1;
    step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678; settle();
    step(); mem_rsp_valid = 0; settle();
    for (int i = 0; i < 3; i++) begin
      chk("rbp_lsu_rsp_valid", lsu_rsp_valid, 1);
      chk("rbp_lsu_rdata_store", lsu_rdata, 0);
      chk("rbp_lsu_err", lsu_rsp_err, 0);
      chk("rbp_ifu_ready_blocked", ifu_req_ready, 0);
      chk("rbp_ifu_rsp_valid", ifu_rsp_valid, 0);
      step();
    end
    lsu_rsp_ready = 1; settle();
    chk("rbp_lsu_rsp_hold", lsu_rsp_valid, 1);
    step(); lsu_rsp_ready = 0; settle();

    // Pending IFU request survived; a new tie now goes to IFU
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wmask = 4'hF; settle();
    chk("tie2_ifu_ready", ifu_req_ready, 1);
    chk("tie2_lsu_ready", lsu_req_ready, 0);
    step(); ifu_req_valid = 0; mem_req_ready = 1; settle();
    chk("tie2_mem_addr", mem_addr, 32'h8000_0004);
    chk("tie2_lsu_ready_blocked", lsu_req_ready, 0);
    step(); mem_req_ready = 0; settle();

    // Timeout: no response for 4 WAIT cycles
    for (int i = 0; i < 4; i++) begin
      chk("to_ifu_rsp_early", ifu_rsp_valid, 0);
      step();
    end
    chk("to_ifu_rsp_valid", ifu_rsp_valid, 1);
    chk("to_ifu_err", ifu_rsp_err, 1);
    chk("to_ifu_rdata", ifu_rdata, 0);
    ifu_rsp_ready = 1;
    step(); ifu_rsp_ready = 0; settle();

    // Tie goes to LSU; response arrives on the expiry cycle and wins
    ifu_req_valid = 1; settle();
    chk("tie3_lsu_ready", lsu_req_ready, 1);
    chk("tie3_ifu_ready", ifu_req_ready, 0);
    step(); lsu_req_valid = 0; ifu_req_valid = 0; mem_req_ready = 1; settle();
    chk("tie3_mem_wen", mem_wen, 0);
    step(); mem_req_ready = 0; settle();
    step(); step(); step();
    chk("late_lsu_rsp_early", lsu_rsp_valid, 0);
    mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    step(); mem_rsp_valid = 0; mem_rdata = 0; settle();
    chk("late_lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("late_lsu_err", lsu_rsp_err, 0);
    chk("late_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
    chk("late_ifu_rsp_valid", ifu_rsp_valid, 0);
    lsu_rsp_ready = 1;
    step(); lsu_rsp_ready = 0; settle();

    // Reset during WAIT of an LSU transaction
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; settle();
    chk("rw_lsu_ready", lsu_req_ready, 1);
    step(); lsu_req_valid = 0; mem_req_ready = 1; settle();
    step(); mem_req_ready = 0; rst_n = 0; settle();
    chk("rw_rst_mem_req_valid", mem_req_valid, 0);
    step(); rst_n = 1; mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
    lsu_rsp_ready = 1; ifu_rsp_ready = 1; settle();
    chk("rw_post_mem_req_valid", mem_req_valid, 0);
    chk("rw_post_lsu_rsp_valid", lsu_rsp_valid, 0);
    step(); mem_rsp_valid = 0; mem_rdata = 0; settle();
    chk("rw_post2_lsu_rsp_valid", lsu_rsp_valid, 0);
    chk("rw_post2_ifu_rsp_valid", ifu_rsp_valid, 0);
    lsu_rsp_ready = 0; ifu_rsp_ready = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0008;
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; settle();
    chk("rw_tie_lsu_ready", lsu_req_ready, 1);
    chk("rw_tie_ifu_ready", ifu_req_ready, 0);
    step(); lsu_req_valid = 0; ifu_req_valid = 0; settle();
    chk("rw_regrant_mem_req_valid", mem_req_valid, 1);
    chk("rw_regrant_mem_addr", mem_addr, 32'h8000_4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060221_mem_arbiter.md
# ysyx_23060221_mem_arbiter

Two-master, one-slave memory arbiter that shares the NPC's single memory port between the IFU (instruction fetch) and the LSU (load/store issued by EXU). It sits between the fetch/load-store units and the memory model, serialising one outstanding transaction at a time. Masters are selected round-robin, and the arbiter returns each response only to the master that owns it. A timeout counter guarantees that a silent slave cannot hang the core.

## Interface
- TIMEOUT, 255: WAIT-state cycles without `mem_rsp_valid` before an error response is returned; legal range 1..255.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- ifu_req_valid / ifu_req_ready  in/out  1/1  IFU request handshake.
- ifu_addr  in  32  fetch address.
- ifu_rsp_valid / ifu_rsp_ready  out/in  1/1  IFU response handshake.
- ifu_rdata  out  32  fetched word.
- ifu_rsp_err  out  1  timeout error flag.
- lsu_req_valid / lsu_req_ready  in/out  1/1  LSU request handshake.
- lsu_addr, lsu_wdata  in  32  access address and store data.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wmask  in  4  byte strobes.
- lsu_rsp_valid / lsu_rsp_ready  out/in  1/1  LSU response handshake.
- lsu_rdata  out  32  load data; 0 for stores.
- lsu_rsp_err  out  1  timeout error flag.
- mem_req_valid / mem_req_ready  out/in  1/1  slave request handshake.
- mem_addr, mem_wdata  out  32  latched request fields.
- mem_wen  out  1  latched write enable.
- mem_wmask  out  4  latched byte strobes.
- mem_rsp_valid  in  1  slave response strobe.
- mem_rdata  in  32  slave read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, request latch, rdata latch, err latch, and an 8-bit timeout counter.
- **IDLE:**
  - Arbitration: if only one master has valid asserted, that master wins.
  - If both have valid asserted, the master other than last_grant wins.
  - The winner's req_ready = 1 combinationally in that cycle.
  - On that edge: latch addr/wen/wdata/wmask into the request latch. For an IFU grant, wen = 0 and wmask = 4'hF.
  - On that edge: set owner and last_grant to the winner and go to REQ.
- **REQ:** mem_req_valid = 1 with the latched fields. When mem_req_ready = 1, go to WAIT and clear the counter to 0.
- **WAIT:**
  - If mem_rsp_valid = 1: latch mem_rdata (0 if wen), set err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: latch rdata = 0, set err = 1, go to RESP.
  - Else: counter + 1.
  - If mem_rsp_valid and expiry occur in the same cycle, the response wins (err = 0).
- **RESP:** the owner's rsp_valid = 1, with rdata/rsp_err driven from the latches. The non-owner's rsp_valid = 0. When the owner's rsp_ready = 1, go to IDLE.
- The non-owner's req_ready = 0 in every state other than IDLE. Its pending request waits with no loss.
- mem_rsp_valid outside WAIT is ignored.
- When no transaction is in progress, mem_addr/mem_wdata hold their last latched values. Only mem_req_valid qualifies them.

## Timing
- Reset (rst_n = 0 at a posedge) is synchronous:
  - state = IDLE, last_grant = IFU (so the first tie goes to LSU), counter = 0, all latches = 0.
  - While rst_n = 0, every valid/ready output is forced 0.
- Reset mid-transaction abandons the transaction. No response is delivered, and mem_req_valid is 0 from the cycle after the reset edge.
- req_ready is combinational from the registered state plus the valid inputs. All other outputs are decoded from registered state/latches; there are no combinational paths from mem_* inputs to outputs.
- Best-case turnaround (mem_req_ready and mem_rsp_valid each asserted on first opportunity, rsp_ready = 1):
  - cycle 0 grant, cycle 1 REQ, cycle 2 WAIT, cycle 3 RESP, cycle 4 IDLE.
  - Next grant no earlier than cycle 4.
- Timeout: with no response, RESP is entered exactly TIMEOUT cycles after entering WAIT.
- One outstanding transaction at a time; no pipelining.

## Test plan
- **Single IFU fetch:** ifu_addr = 0x80000000; mem_rsp_valid one cycle after acceptance with rdata 0x00100073 -> ifu_rsp_valid in cycle 3 with ifu_rdata = 0x00100073 and err = 0; lsu_rsp_valid stays 0.
- **Tie after reset:** both valid in cycle 0 -> lsu_req_ready = 1 and ifu_req_ready = 0. The next tie grants IFU, then LSU, alternating.
- **LSU store:** addr 0x80001000, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_wen = 1 and mem_wmask = 4'b0011 while mem_req_valid; lsu_rdata = 0.
- **Backpressure:** mem_req_ready held 0 for 5 cycles -> fields stable and mem_req_valid held. Then rsp_ready held 0 for 3 cycles -> rsp_valid/rdata stable, no new grant.
- **Timeout:** TIMEOUT = 4, no mem_rsp_valid -> rsp_err = 1 and rdata = 0 exactly 4 cycles after entering WAIT. A response on the 4th cycle instead yields err = 0 with the slave data.
- **Reset in WAIT:** rst_n low for 1 cycle -> no rsp_valid is ever produced, state IDLE. The next request is granted normally, with the LSU winning a tie.
